// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
// Holds the state encodings, parity codes and the frame width normaliser.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int DATA_BITS_MIN = 5;

    // Out-of-range widths fall back to 8, then clip to the data port width.
    function automatic logic [3:0] norm_bits(
        input logic [3:0] raw,
        input logic [3:0] max_bits
    );
        logic [3:0] n;
        n = (raw < 4'(DATA_BITS_MIN) || raw > 4'd9) ? 4'd8 : raw;
        return (n > max_bits) ? max_bits : n;
    endfunction

endpackage

// File: rtl/double_ff_sync.sv
// Two-flop synchroniser for a single asynchronous bit.
// Ports: sysclk_in, nrst_in, d_in (async), q_out (synchronised); NRST_VAL = reset level.
module double_ff_sync #(
    parameter logic NRST_VAL = 1'b1
) (
    input  logic sysclk_in,
    input  logic nrst_in,
    input  logic d_in,
    output logic q_out
);

    logic meta;

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            meta  <= NRST_VAL;
            q_out <= NRST_VAL;
        end else begin
            meta  <= d_in;
            q_out <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// Bit-period tick counter with 3-sample majority vote around mid-bit.
// Ports: sysclk_in, nrst_in, divpulse_in, run_in, rx_in -> bit_val_out, bit_strobe_out, bit_end_out.
module uart_rx_sampler #(
    parameter int OVERSAMPLING = 16
) (
    input  logic sysclk_in,
    input  logic nrst_in,
    input  logic divpulse_in,
    input  logic run_in,
    input  logic rx_in,
    output logic bit_val_out,
    output logic bit_strobe_out,
    output logic bit_end_out
);

    localparam int TW = $clog2(OVERSAMPLING);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLING - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLING / 2);
    localparam logic [TW-1:0] T_PRE  = TW'(OVERSAMPLING / 2 - 1);
    localparam logic [TW-1:0] T_POST = TW'(OVERSAMPLING / 2 + 1);

    logic [TW-1:0] tick_cnt;
    logic          s0;
    logic          s1;

    // Counter is held at zero while the receiver is idle, so entering
    // START always begins a fresh bit period.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            tick_cnt <= '0;
            s0       <= 1'b1;
            s1       <= 1'b1;
        end else if (!run_in) begin
            tick_cnt <= '0;
        end else if (divpulse_in) begin
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == T_PRE) s0 <= rx_in;
            if (tick_cnt == T_MID) s1 <= rx_in;
        end
    end

    // Third sample is the live line at the decision tick.
    assign bit_val_out    = (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
    assign bit_strobe_out = run_in & divpulse_in & (tick_cnt == T_POST);
    assign bit_end_out    = run_in & divpulse_in & (tick_cnt == T_LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-9 data bits, N/E/O parity, 1/2 stop) with valid/ack hold.
// Ports: sysclk_in, nrst_in, divpulse_in, rx_serial_in, cfg_*, data_ack_in -> data_vld_out,
// rx_data_out, parity/frame/overrun errors, state_dbg_out; break_out with UART_RX_BREAK_DETECT_EN.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING  = 16,
    parameter int DATA_BITS_MAX = 9
) (
    input  logic                     sysclk_in,
    input  logic                     nrst_in,
    input  logic                     divpulse_in,
    input  logic                     rx_serial_in,
    input  logic [3:0]               cfg_data_bits_in,
    input  logic [1:0]               cfg_parity_in,
    input  logic                     cfg_stop2_in,
    input  logic                     data_ack_in,
    output logic                     data_vld_out,
    output logic [DATA_BITS_MAX-1:0] rx_data_out,
    output logic                     parity_err_out,
    output logic                     frame_err_out,
    output logic                     overrun_err_out,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                     break_out,
`endif
    output logic [2:0]               state_dbg_out
);

    rx_state_e state;

    logic rx_s;
    logic bit_val;
    logic bit_stb;
    logic bit_end;

    logic [3:0] nb_q;
    logic [1:0] par_q;
    logic       stop2_q;

    logic [3:0]               bit_idx;
    logic                     stop_idx;
    logic [DATA_BITS_MAX-1:0] shreg;
    logic                     par_acc;
    logic                     perr;
    logic                     ferr;

    logic done;
    logic fin_ferr;
    logic par_en;
    logic par_exp;

`ifdef UART_RX_BREAK_DETECT_EN
    localparam int TW = $clog2(OVERSAMPLING);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLING - 1);

    logic          allz;
    logic          brk_wait;
    logic [TW-1:0] hi_cnt;
    logic          fin_brk;
`endif

    double_ff_sync #(
        .NRST_VAL (1'b1)
    ) u_sync (
        .sysclk_in (sysclk_in),
        .nrst_in   (nrst_in),
        .d_in      (rx_serial_in),
        .q_out     (rx_s)
    );

    uart_rx_sampler #(
        .OVERSAMPLING (OVERSAMPLING)
    ) u_smp (
        .sysclk_in      (sysclk_in),
        .nrst_in        (nrst_in),
        .divpulse_in    (divpulse_in),
        .run_in         (state != IDLE),
        .rx_in          (rx_s),
        .bit_val_out    (bit_val),
        .bit_strobe_out (bit_stb),
        .bit_end_out    (bit_end)
    );

    assign par_en   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign par_exp  = par_acc ^ (par_q == PAR_ODD);
    assign fin_ferr = ferr | ~bit_val;

`ifdef UART_RX_BREAK_DETECT_EN
    assign fin_brk = allz & ~bit_val;
    assign done    = (state == STOP) & bit_stb & ~brk_wait
                   & (stop_idx == stop2_q);
`else
    assign done    = (state == STOP) & bit_stb
                   & (stop_idx == stop2_q);
`endif

    assign state_dbg_out = state;

    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state    <= IDLE;
            nb_q     <= 4'd8;
            par_q    <= PAR_NONE;
            stop2_q  <= 1'b0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            allz     <= 1'b0;
            brk_wait <= 1'b0;
            hi_cnt   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // Shadow copy: cfg changes mid-frame are ignored.
                    nb_q    <= norm_bits(cfg_data_bits_in,
                                         4'(DATA_BITS_MAX));
                    par_q   <= cfg_parity_in;
                    stop2_q <= cfg_stop2_in;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bit_stb && bit_val) begin
                        state <= IDLE;
                    end else if (bit_end) begin
                        state    <= DATA;
                        bit_idx  <= '0;
                        stop_idx <= 1'b0;
                        shreg    <= '0;
                        par_acc  <= 1'b0;
                        perr     <= 1'b0;
                        ferr     <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        allz     <= 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (bit_stb) begin
                        for (int i = 0; i < DATA_BITS_MAX; i++) begin
                            if (bit_idx == 4'(i)) shreg[i] <= bit_val;
                        end
                        par_acc <= par_acc ^ bit_val;
`ifdef UART_RX_BREAK_DETECT_EN
                        allz    <= allz & ~bit_val;
`endif
                    end
                    if (bit_end) begin
                        if (bit_idx == nb_q - 4'd1) begin
                            state <= par_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_stb) begin
                        perr <= bit_val ^ par_exp;
`ifdef UART_RX_BREAK_DETECT_EN
                        allz <= allz & ~bit_val;
`endif
                    end
                    if (bit_end) state <= STOP;
                end
                STOP: begin
`ifdef UART_RX_BREAK_DETECT_EN
                    if (brk_wait) begin
                        // Hold off resync until a full bit period of idle line.
                        if (divpulse_in) begin
                            if (!rx_s) begin
                                hi_cnt <= '0;
                            end else if (hi_cnt == T_LAST) begin
                                hi_cnt   <= '0;
                                brk_wait <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                hi_cnt <= hi_cnt + 1'b1;
                            end
                        end
                    end else if (done) begin
                        if (fin_brk) begin
                            brk_wait <= 1'b1;
                            hi_cnt   <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (bit_stb) begin
                            ferr <= fin_ferr;
                            allz <= allz & ~bit_val;
                        end
                        if (bit_end) stop_idx <= 1'b1;
                    end
`else
                    if (done) begin
                        state <= IDLE;
                    end else begin
                        if (bit_stb) ferr <= fin_ferr;
                        if (bit_end) stop_idx <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus-side hold register; an ack in the completion cycle frees the
    // slot so the new frame loads instead of overrunning.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            data_vld_out    <= 1'b0;
            rx_data_out     <= '0;
            parity_err_out  <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_out       <= 1'b0;
`endif
        end else if (done) begin
            if (!data_vld_out || data_ack_in) begin
                data_vld_out    <= 1'b1;
                rx_data_out     <= shreg;
                parity_err_out  <= perr;
                frame_err_out   <= fin_ferr;
                overrun_err_out <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                break_out       <= fin_brk;
`endif
            end else begin
                overrun_err_out <= 1'b1;
            end
        end else if (data_ack_in && data_vld_out) begin
            data_vld_out    <= 1'b0;
            parity_err_out  <= 1'b0;
            frame_err_out   <= 1'b0;
            overrun_err_out <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_out       <= 1'b0;
`endif
        end
    end

endmodule
